// File: rtl/pipe_stage_reg_if.sv
// Bus bundle for pipe_stage_reg: upstream payload/control, hazard controls,
// and the registered outputs of the last stage plus the late lane.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int LATE_W = 32,
  parameter int DEPTH  = 1
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [LATE_W-1:0] late_in;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [LATE_W-1:0] late_out;
  logic [OCC_W-1:0]  occupancy;

  // Upstream stage / hazard unit side.
  modport master (
    output in_valid, in_data, in_ctrl, late_in, stall, flush,
    input  out_valid, out_data, out_ctrl, late_out, occupancy
  );

  // Pipeline register side.
  modport slave (
    input  in_valid, in_data, in_ctrl, late_in, stall, flush,
    output out_valid, out_data, out_ctrl, late_out, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep CPU pipeline register with stall, flush and occupancy count.
// A separate late lane captures memory read data on the falling edge
// (LATE_NEG=1) or together with the last stage on the rising edge.
// Every output comes straight from a register or from register-only logic.
module pipe_stage_reg #(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 8,
  parameter int LATE_W     = 32,
  parameter int DEPTH      = 1,
  parameter int LATE_NEG   = 1,
  parameter int FLUSH_DATA = 0
) (
  input  logic            clk,
  input  logic            nrst,
  pipe_stage_reg_if.slave p
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             vld_q,  vld_d;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [LATE_W-1:0]            late_q, late_d;
  logic [OCC_W-1:0]             occ;

  // Stage chain next state: flush squashes, stall holds, otherwise shift by one.
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (p.flush) begin
      vld_d  = '0;
      ctrl_d = '0;
      if (FLUSH_DATA != 0) begin
        data_d = '0;
      end
    end else if (!p.stall) begin
      vld_d[0]  = p.in_valid;
      ctrl_d[0] = p.in_ctrl;
      data_d[0] = p.in_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        ctrl_d[k] = ctrl_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end
  end

  // Stage chain registers, cleared asynchronously.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      vld_q  <= '0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  // Late lane next state: same squash/hold/load priority as the stages.
  always_comb begin
    late_d = late_q;
    if (p.flush) begin
      late_d = '0;
    end else if (!p.stall) begin
      late_d = p.late_in;
    end
  end

  generate
    if (LATE_NEG != 0) begin : g_late_neg
      // Falling-edge capture gives memory read data an extra half cycle.
      always_ff @(negedge clk or posedge nrst) begin
        if (nrst) late_q <= '0;
        else      late_q <= late_d;
      end
    end else begin : g_late_pos
      // Rising-edge capture, in step with the last stage.
      always_ff @(posedge clk or posedge nrst) begin
        if (nrst) late_q <= '0;
        else      late_q <= late_d;
      end
    end
  endgenerate

  // Popcount of valid bits; bounded by DEPTH so it cannot wrap.
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(vld_q[k]);
    end
  end

  // Bubbles never present control bits, so write enables stay low.
  assign p.out_valid = vld_q[DEPTH-1];
  assign p.out_data  = data_q[DEPTH-1];
  assign p.out_ctrl  = vld_q[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
  assign p.late_out  = late_q;
  assign p.occupancy = occ;
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register.
- DEPTH-deep chain of pipeline registers carrying a DATA_W payload, a CTRL_W control word and a per-stage valid bit.
- Adds stall (hold), flush (bubble insertion) and an occupancy count.
- Provides a configurable "late" lane for memory read data that is captured on the falling edge or the rising edge.
- Used between any two CPU pipeline stages (IF/ID through MEM/WB).

Parameters:
- DATA_W, 96: payload width (pc4, ALU result, pc, instruction or similar, concatenated).
- CTRL_W, 8: control-signal width; cleared on flush.
- LATE_W, 32: late-lane width (memory read data).
- DEPTH, 1: number of register stages, 1..8.
- LATE_NEG, 1: 1 = late lane captured on negedge clk; 0 = captured on posedge with the last stage.
- FLUSH_DATA, 0: 1 = flush also zeroes payload; 0 = payload held, only ctrl and valid cleared.

Ports:
- clk, input, 1: pipeline clock.
- nrst, input, 1: reset, asynchronous, active-high. Asserted (1) forces reset values immediately.
- in_valid, input, 1: upstream stage holds a real instruction.
- in_data, input, DATA_W: payload into stage 0.
- in_ctrl, input, CTRL_W: control word into stage 0.
- late_in, input, LATE_W: late-arriving data for the last stage.
- stall, input, 1: hazard unit hold; all stages keep their contents.
- flush, input, 1: squash all stages (branch or exception).
- out_valid, output, 1: valid bit of stage DEPTH-1.
- out_data, output, DATA_W: payload of stage DEPTH-1.
- out_ctrl, output, CTRL_W: control word of stage DEPTH-1. Forced to 0 whenever out_valid=0.
- late_out, output, LATE_W: late-lane register.
- occupancy, output, $clog2(DEPTH+1): count of valid stages.

Behaviour:

Reset (nrst=1, asynchronous, any clock phase):
- All stage valid, ctrl and data registers = 0.
- late_out = 0; occupancy = 0.
- Deassertion takes effect at the first posedge after nrst falls.

Advance (posedge, stall=0, flush=0):
- Stage 0 <= {in_valid, in_ctrl, in_data}.
- Stage k <= stage k-1 for k = 1..DEPTH-1.
- Latency in to out = DEPTH cycles.

Stall (posedge, stall=1, flush=0):
- Every stage holds, including valid.
- Inputs are ignored; the upstream stage is responsible for holding its own values.

Flush (posedge, flush=1):
- Overrides stall.
- All valid = 0 and all ctrl = 0. Payload is zeroed only if FLUSH_DATA=1, otherwise held.
- Stage 0 does not capture inputs that cycle.
- occupancy = 0 on the next cycle.

Bubble rule:
- A stage with valid=0 presents out_ctrl = 0, so register-file and memory write enables are never asserted by bubbles.
- Payload passes through unchanged.

Late lane, LATE_NEG=1:
- At each negedge: if flush=1, late_out <= 0. Else if stall=0, late_out <= late_in. Else hold.
- stall and flush are sampled at the negedge itself.
- The value is visible half a cycle after the posedge that advanced the last stage.

Late lane, LATE_NEG=0:
- late_out follows the same advance/stall/flush rule as the last stage at posedge.
- It is zeroed on flush regardless of FLUSH_DATA.

Occupancy:
- Combinational popcount of the stage valid bits.
- Max DEPTH, no wrap.

Simultaneous events:
- nrst beats flush, flush beats stall, stall beats advance.
- in_valid=0 with stall=0 inserts a bubble into stage 0.

Timing constraint:
- No combinational path from any input to out_* or occupancy.
- late_out has no combinational path from late_in.

Test Plan:
1. DEPTH=1, LATE_NEG=1. Drive in_data=0x...00400004, in_ctrl=0x05, in_valid=1 and late_in=0xDEADBEEF, then posedge. Required: out_* update at that posedge; late_out=0xDEADBEEF after the following negedge, not before.
2. DEPTH=3. Stream valid tokens A,B,C,D on consecutive cycles. Required: A on outputs exactly 3 posedges after entry, then B, C, D on successive cycles; occupancy reads 1,2,3,3.
3. DEPTH=3, pipeline full. Assert stall for 2 cycles while in_data changes. Required: outputs and occupancy frozen at 3; no token lost or duplicated after release.
4. DEPTH=3, FLUSH_DATA=0. Assert flush together with stall on a full pipe. Required: next cycle occupancy=0, out_valid=0, out_ctrl=0x00 and out_data unchanged. With FLUSH_DATA=1, out_data=0 as well.
5. Mid-stream, pulse nrst high for 3 ns between clock edges. Required: all outputs 0 immediately, without waiting for an edge. The first token after release appears DEPTH cycles later.
6. LATE_NEG=0, DEPTH=2. Drive late_in=0x12345678 with stall=0, then flush. Required: late_out=0x12345678 after the first posedge, then 0 after the flush posedge.
